// File: rtl/demux_sched_1x4_if.sv
// Handshake bundle between a single source, the 1x4 scheduler and four sinks.
//   in_valid/in_data/in_ready : source beat handshake
//   out_ready[3:0]            : per-channel sink ready
//   out_valid[3:0]/out_data   : per-channel valid (one-hot or zero), shared payload
//   sel                       : currently or last granted channel
//   busy                      : scheduler not idle
// slave  = scheduler side, master = environment (source + sinks) side.
interface demux_sched_1x4_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    out_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    sel;
  logic          busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/demux_sched_1x4.sv
// Burst scheduler demultiplexing one source stream onto four sink channels.
// A channel is granted round-robin (starting after the last grant) and keeps
// the grant for BURST accepted beats; a single output register carries each
// beat to the granted sink.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : demux_sched_1x4_if.slave handshake bundle (see interface file)
// Parameters: DW data width (must match the interface DW), BURST beats per
// grant (1..16).
module demux_sched_1x4 #(
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  demux_sched_1x4_if.slave   bus
);

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic          vld;
  logic [DW-1:0] data_q;
  logic [CW-1:0] cnt;
  logic [1:0]    sel_q;

  logic [1:0]    cand_c;
  logic [1:0]    pick_c;
  logic          found_c;
  logic          in_ready_c;
  logic          accept_c;
  logic          consume_c;
  logic          last_c;

  // Round-robin search: first ready channel starting at sel+1.
  always_comb begin
    cand_c  = sel_q;
    pick_c  = sel_q;
    found_c = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand_c = sel_q + 2'(i);
      if (!found_c && bus.out_ready[cand_c]) begin
        pick_c  = cand_c;
        found_c = 1'b1;
      end
    end
  end

  // The slot can take a new beat if empty or being emptied this cycle.
  always_comb begin
    in_ready_c = rstn && (state == XFER) && (!vld || bus.out_ready[sel_q]);
    accept_c   = bus.in_valid && in_ready_c;
    consume_c  = vld && bus.out_ready[sel_q];
    last_c     = ((cnt + 5'd1) == CW'(BURST));
  end

  // Scheduler state, output register and grant bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      vld    <= 1'b0;
      data_q <= '0;
      cnt    <= '0;
      sel_q  <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && found_c) begin
            sel_q <= pick_c;
            cnt   <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (accept_c) begin
            data_q <= bus.in_data;
            vld    <= 1'b1;
            cnt    <= cnt + 5'd1;
            if (last_c) begin
              state <= DRAIN;
            end
          end else if (consume_c) begin
            vld <= 1'b0;
          end
        end
        DRAIN: begin
          if (consume_c) begin
            vld   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_demux_sched_1x4.sv
// Directed bench for demux_sched_1x4: rotation, single-ready channel,
// sink stall, sparse input, asynchronous reset mid-burst, no-ready idle.
module tb_demux_sched_1x4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  int checks = 0;
  int errors = 0;

  demux_sched_1x4_if #(.DW(8)) bus ();

  demux_sched_1x4 #(.DW(8), .BURST(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;

    // Reset values, checked before any clock edge.
    #1 rstn = 1'b0;
    #1;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sel",       32'(bus.sel),       32'd3);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);

    // All channels ready, continuous source: grants rotate 0,1,2,3.
    @(negedge clk);
    rstn          = 1'b1;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("rot_grant_sel",   32'(bus.sel),       32'(b));
      check("rot_grant_busy",  32'(bus.busy),      32'd1);
      check("rot_grant_rdy",   32'(bus.in_ready),  32'd1);
      check("rot_grant_vld",   32'(bus.out_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
        bus.in_data = 8'(16 + 4 * b + i);
        @(negedge clk);
        check("rot_data",  32'(bus.out_data),  32'(16 + 4 * b + i));
        check("rot_valid", 32'(bus.out_valid), 32'(1 << b));
      end
      check("rot_drain_rdy",  32'(bus.in_ready), 32'd0);
      check("rot_drain_busy", 32'(bus.busy),     32'd1);
      @(negedge clk);
      check("rot_idle_busy",  32'(bus.busy),      32'd0);
      check("rot_idle_vld",   32'(bus.out_valid), 32'd0);
    end

    // Only channel 2 ready, sel=3: grant ch2, then ch2 again.
    bus.out_ready = 4'b0100;
    @(negedge clk);
    check("one_grant_sel",  32'(bus.sel),  32'd2);
    check("one_grant_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(32 + i);
      @(negedge clk);
      check("one_data",  32'(bus.out_data),  32'(32 + i));
      check("one_valid", 32'(bus.out_valid), 32'h4);
    end
    @(negedge clk);
    check("one_idle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("one_regrant_sel",  32'(bus.sel),  32'd2);
    check("one_regrant_busy", 32'(bus.busy), 32'd1);

    // Sparse source: count advances only on accepts.
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("sp_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rstn          = 1'b1;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("sp_grant_sel", 32'(bus.sel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(80 + i);
      @(negedge clk);
      check("sp_data",  32'(bus.out_data),  32'(80 + i));
      check("sp_valid", 32'(bus.out_valid), 32'h1);
      if (i < 3) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sp_gap_vld",  32'(bus.out_valid), 32'd0);
        check("sp_gap_rdy",  32'(bus.in_ready),  32'd1);
        check("sp_gap_busy", 32'(bus.busy),      32'd1);
        check("sp_gap_data", 32'(bus.out_data),  32'(80 + i));
      end
    end
    check("sp_drain_rdy",  32'(bus.in_ready), 32'd0);
    check("sp_drain_busy", 32'(bus.busy),     32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("sp_idle_busy", 32'(bus.busy),      32'd0);
    check("sp_idle_vld",  32'(bus.out_valid), 32'd0);

    // Sink stall on ch0 after two beats: nothing lost, burst completes.
    rstn = 1'b0;
    @(negedge clk);
    rstn          = 1'b1;
    bus.out_ready = 4'b0001;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("st_grant_sel", 32'(bus.sel), 32'd0);
    bus.in_data = 8'h40;
    @(negedge clk);
    bus.in_data = 8'h41;
    @(negedge clk);
    check("st_beat2", 32'(bus.out_data), 32'h41);
    bus.out_ready = 4'b0000;
    bus.in_data   = 8'h42;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_hold_rdy",  32'(bus.in_ready),  32'd0);
      check("st_hold_data", 32'(bus.out_data),  32'h41);
      check("st_hold_vld",  32'(bus.out_valid), 32'h1);
      check("st_hold_sel",  32'(bus.sel),       32'd0);
    end
    bus.out_ready = 4'b0001;
    @(negedge clk);
    check("st_beat3", 32'(bus.out_data), 32'h42);
    bus.in_data = 8'h43;
    @(negedge clk);
    check("st_beat4",     32'(bus.out_data), 32'h43);
    check("st_drain_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("st_idle_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-burst on ch1 drops the buffered beat.
    rstn = 1'b0;
    @(negedge clk);
    rstn          = 1'b1;
    bus.out_ready = 4'b0010;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("ar_grant_sel", 32'(bus.sel), 32'd1);
    bus.in_data = 8'h60;
    @(negedge clk);
    bus.out_ready = 4'b0000;
    check("ar_pre_vld",  32'(bus.out_valid), 32'h2);
    check("ar_pre_data", 32'(bus.out_data),  32'h60);
    #2 rstn = 1'b0;
    #1;
    check("ar_vld",  32'(bus.out_valid), 32'd0);
    check("ar_busy", 32'(bus.busy),      32'd0);
    check("ar_sel",  32'(bus.sel),       32'd3);
    check("ar_rdy",  32'(bus.in_ready),  32'd0);
    check("ar_data", 32'(bus.out_data),  32'd0);

    // No sink ready: stay idle; raising ch1 ready grants ch1 next edge.
    @(negedge clk);
    rstn          = 1'b1;
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("nr_busy", 32'(bus.busy),      32'd0);
      check("nr_rdy",  32'(bus.in_ready),  32'd0);
      check("nr_sel",  32'(bus.sel),       32'd3);
      check("nr_vld",  32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 4'b0010;
    @(negedge clk);
    check("nr_grant_sel",  32'(bus.sel),  32'd1);
    check("nr_grant_busy", 32'(bus.busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_sched_1x4.md
DEMUX_SCHED_1X4 -- requirements
Module: demux_sched_1x4

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter BURST, default 4, beats per grant (legal 1..16).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, source beat available.
REQ-006 SHALL have port in_data, input, DW, source beat payload.
REQ-007 SHALL have port in_ready, output, 1, beat accepted on the edge where in_valid and in_ready are both 1.
REQ-008 SHALL have port out_ready, input, 4, per-channel sink ready.
REQ-009 SHALL have port out_valid, output, 4, per-channel beat valid, at most one bit set (one-hot or zero).
REQ-010 SHALL have port out_data, output, DW, registered payload shared by all channels.
REQ-011 SHALL have port sel, output, 2, currently or last granted channel.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, XFER and DRAIN.
REQ-014 SHALL hold one output register (out_data plus a valid flag); out_valid SHALL equal the valid flag decoded onto bit sel.
REQ-015 In IDLE with in_valid=1, the block SHALL search channels round-robin starting at (sel+1) mod 4 for the first channel with out_ready=1.
REQ-016 If that search finds a channel, the block SHALL load sel with it, clear the beat count and enter XFER on the next edge.
REQ-017 If no channel is ready, the block SHALL stay in IDLE with sel unchanged.
REQ-018 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-019 in_ready SHALL be 1 only in XFER with (valid flag=0 or out_ready[sel]=1); this is combinational from state, the flag and out_ready.
REQ-020 On a beat accept, out_data SHALL load in_data, the valid flag SHALL set, and the beat count SHALL increment.
REQ-021 When the output beat is consumed (out_valid[sel]=1 and out_ready[sel]=1) with no accept on the same edge, the valid flag SHALL clear.
REQ-022 When consume and accept occur on the same edge, the flag SHALL stay 1 and new data SHALL load (full throughput, one beat per clock).
REQ-023 The accept that brings the count to BURST SHALL move the state to DRAIN; count width SHALL be 5 bits and SHALL not wrap within a grant.
REQ-024 In DRAIN, in_ready SHALL be 0; the block SHALL return to IDLE on the edge where the valid flag clears.
REQ-025 Latency: in_data accepted at edge N SHALL appear on out_data with out_valid[sel]=1 after edge N (one register stage).
REQ-026 IDLE-to-XFER arbitration SHALL cost one cycle; no beat SHALL be accepted in IDLE.
REQ-027 sel SHALL not change in XFER or DRAIN, even if out_ready[sel] drops; the block SHALL then stall, with no timeout.
REQ-028 out_valid SHALL remain stable, with out_data unchanged, until consumed.
REQ-029 A beat presented while in_valid=0 mid-burst SHALL not count; the grant SHALL persist until BURST beats are accepted.

Reset
REQ-030 On rstn=0, asynchronously: state=IDLE, valid flag=0, out_valid=4'b0000, out_data=0, count=0, sel=2'd3 (so the first grant prefers channel 0), busy=0.
REQ-031 in_ready SHALL be 0 while rstn=0.
REQ-032 Reset asserted mid-burst SHALL drop any buffered beat without delivering it.
REQ-033 The first arbitration after rstn rises SHALL be evaluated on the first clock edge.

Verification
REQ-034 Reset and all out_ready=4'b1111, in_valid=1, data 0x10..0x1F -> grants rotate 0,1,2,3, each 4 beats; ch0 receives 0x10-0x13, ch1 receives 0x14-0x17; 1 idle cycle plus 1 drain cycle between bursts.
REQ-035 out_ready=4'b0100 only, sel=3 after reset -> grant ch2 and its 4 beats; the next grant is ch2 again (only ready channel).
REQ-036 In XFER on ch0 after 2 beats, drop out_ready[0] for 3 cycles -> in_ready=0, out_data holds beat 2, sel=0, no beat lost; the burst completes after release.
REQ-037 in_valid toggles 1,0,1,0 in XFER -> count advances only on accepts; DRAIN is entered after the 4th accept.
REQ-038 Assert rstn=0 mid-burst with out_valid=4'b0010 -> out_valid=0, busy=0 immediately without waiting for a clock edge; sel=3.
REQ-039 out_ready=4'b0000 with in_valid=1 for 10 cycles -> state stays IDLE, in_ready=0; raising out_ready[1] gives a grant to ch1 on the next edge.
